// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Performs a WIDTH-bit add by stepping one shared external 4-bit adder slice
// through the operands, one nibble per clock, least significant nibble first.
//
// Optional feature macro: NIBBLE_SERIAL_SUB_EN
//   When defined, adds op_sub. With op_sub=1 the slice is fed ~B with a
//   carry-in of 1, giving a - b; c_out=1 then means no borrow.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   op_sub              (NIBBLE_SERIAL_SUB_EN only) subtract request
//   in_valid/in_ready   operand handshake (a, b, c_in sampled on accept)
//   out_valid/out_ready result handshake (sum, c_out)
//   add_x/add_y/add_ci  drive the external adder slice
//   add_s/add_co        combinational results from the adder slice
//
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             op_sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  output logic             add_ci,
  input  logic [3:0]       add_s,
  input  logic             add_co
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-1:0]   op_a_q,      op_a_d;
  logic [WIDTH-1:0]   op_b_q,      op_b_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic               c_out_q,     c_out_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic               sub_q,       sub_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  // Next-state, next-datapath and adder-slice drive
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub_d       = sub_q;
`endif
    add_x       = 4'h0;
    add_y       = 4'h0;
    add_ci      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_a_d     = a;
          op_b_d     = b;
          idx_d      = '0;
          carry_d    = c_in;
`ifdef NIBBLE_SERIAL_SUB_EN
          sub_d      = op_sub;
          // a - b == a + ~b + 1
          if (op_sub) carry_d = 1'b1;
`endif
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        // Select the current nibble and write back the slice result in place
        for (int unsigned k = 0; k < NIB; k++) begin
          if (idx_q == IDX_W'(k)) begin
            add_x = op_a_q[4*k +: 4];
`ifdef NIBBLE_SERIAL_SUB_EN
            add_y = sub_q ? ~op_b_q[4*k +: 4] : op_b_q[4*k +: 4];
`else
            add_y = op_b_q[4*k +: 4];
`endif
            sum_d[4*k +: 4] = add_s;
          end
        end
        add_ci  = carry_q;
        carry_d = add_co;

        if (idx_q == IDX_W'(NIB - 1)) begin
          c_out_d     = add_co;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        // Result is held until consumed; sum/c_out keep their value afterwards
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16): directed vector
// table, back-pressure and mid-operation reset sequences, and random
// operations against a plain-arithmetic reference.

module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic [3:0]  add_x;
  logic [3:0]  add_y;
  logic        add_ci;
  logic [3:0]  add_s;
  logic        add_co;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic        op_sub;
`endif

  int tests;
  int fails;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef NIBBLE_SERIAL_SUB_EN
    .op_sub    (op_sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co)
  );

  // External 4-bit ripple adder slice
  logic [4:0] slice_res;
  assign slice_res = 5'(add_x) + 5'(add_y) + 5'(add_ci);
  assign add_s  = slice_res[3:0];
  assign add_co = slice_res[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: {c_out, sum} of an unsigned 16-bit add, or a - b with no-borrow flag
  function automatic logic [16:0] ref_model(input logic [15:0] av, input logic [15:0] bv,
                                            input logic ci, input logic sv);
    logic [31:0] r;
    if (sv) begin
      r = 32'(av) - 32'(bv);
      return {(av >= bv), r[15:0]};
    end
    r = 32'(av) + 32'(bv) + 32'(ci);
    return r[16:0];
  endfunction

  // One full transaction; hold = cycles of out_ready=0 after the result appears
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sv, input logic [15:0] es, input logic ec,
                        input int hold, input string nm);
    logic [3:0] yn;
    chk({nm, ".in_ready_idle"}, 32'(in_ready), 32'(1));
    a = av; b = bv; c_in = ci; in_valid = 1'b1;
    out_ready = (hold == 0);
`ifdef NIBBLE_SERIAL_SUB_EN
    op_sub = sv;
`endif
    @(posedge clk);
    @(negedge clk);
    // Operands change during RUN and must be ignored
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
`ifdef NIBBLE_SERIAL_SUB_EN
    op_sub = 1'($urandom);
`endif
    for (int k = 0; k < 4; k++) begin
      yn = bv[4*k +: 4];
      if (sv) yn = ~yn;
      chk($sformatf("%s.add_x%0d", nm, k), 32'(add_x), 32'(av[4*k +: 4]));
      chk($sformatf("%s.add_y%0d", nm, k), 32'(add_y), 32'(yn));
      if (k == 0) chk({nm, ".add_ci0"}, 32'(add_ci), 32'(sv ? 1'b1 : ci));
      chk($sformatf("%s.busy_valid%0d", nm, k), 32'(out_valid), 32'(0));
      chk($sformatf("%s.busy_ready%0d", nm, k), 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(1));
    chk({nm, ".sum"}, 32'(sum), 32'(es));
    chk({nm, ".c_out"}, 32'(c_out), 32'(ec));
    chk({nm, ".in_ready_done"}, 32'(in_ready), 32'(0));
    chk({nm, ".slice_idle"}, 32'({add_x, add_y, add_ci}), 32'(0));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      chk($sformatf("%s.hold_valid%0d", nm, h), 32'(out_valid), 32'(1));
      chk($sformatf("%s.hold_sum%0d", nm, h), 32'({c_out, sum}), 32'({ec, es}));
      chk($sformatf("%s.hold_ready%0d", nm, h), 32'(in_ready), 32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, ".post_ready"}, 32'(in_ready), 32'(1));
    chk({nm, ".post_valid"}, 32'(out_valid), 32'(0));
    chk({nm, ".post_sum_hold"}, 32'({c_out, sum}), 32'({ec, es}));
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    int          hold;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [16:0] m;
    logic [15:0] ra, rb;
    logic        rc, rs;

    tests = 0; fails = 0;
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 0};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 10};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 0};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    op_sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset.in_ready", 32'(in_ready), 32'(1));
    chk("reset.out_valid", 32'(out_valid), 32'(0));
    chk("reset.sum", 32'(sum), 32'(0));
    chk("reset.c_out", 32'(c_out), 32'(0));
    chk("reset.slice", 32'({add_x, add_y, add_ci}), 32'(0));

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, vecs[i].es, vecs[i].ec,
             vecs[i].hold, $sformatf("vec%0d", i));

    // Reset while the third nibble is in the slice
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.idx2_x", 32'(add_x), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.in_ready", 32'(in_ready), 32'(1));
    chk("midrst.out_valid", 32'(out_valid), 32'(0));
    chk("midrst.sum", 32'(sum), 32'(0));
    chk("midrst.c_out", 32'(c_out), 32'(0));
    @(negedge clk);
    chk("midrst.stays_idle", 32'(out_valid), 32'(0));
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0, "post_rst");

`ifdef NIBBLE_SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, "sub_borrow");
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0, "sub_noborrow");
    run_op(16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 0, "sub_equal");
`endif

    // Random operations against the reference
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 10 == 3) ra = 16'hFFFF;
      m = ref_model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, m[15:0], m[16], (i % 7 == 0) ? 3 : 0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
